ahb_copy_master: RTL and testbench
==================================

# ahb_copy_master

AHB-Lite bus initiator that copies a block of 32-bit words from a source address range to a destination address range on the same AHB-Lite bus. Software or a control FSM supplies source, destination and length and pulses `start`. The block then issues strictly non-pipelined single read/write transfers until it finishes or the bus returns an error. It sits alongside the processor as a second master behind the bus interconnect, talking to the on-chip memory slaves.

## Interface
- `LENW`, default 16: width of the word-count field; maximum transfer is 2^LENW−1 words.
- `HCLK` input 1: system clock; all state changes on its rising edge.
- `HRESETn` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle command strobe; ignored while `busy`=1.
- `src_addr` input 32: source byte address, sampled with `start`; bits [1:0] forced to 0.
- `dst_addr` input 32: destination byte address, sampled with `start`; bits [1:0] forced to 0.
- `len` input LENW: number of words to copy, sampled with `start`.
- `busy` output 1: copy in progress.
- `done` output 1: one-cycle pulse at completion, including error completion.
- `error` output 1: sticky; set by an HRESP ERROR; cleared by the next accepted `start`.
- `words_done` output LENW: count of words fully written in the current or last copy.
- `HADDR` output 32, `HTRANS` output 2, `HWRITE` output 1, `HSIZE` output 3, `HWDATA` output 32: AHB-Lite master signals.
- `HBURST` output 3, `HPROT` output 4, `HMASTLOCK` output 1: tied to 3'b000 (SINGLE), 4'b0011, 0.
- `HREADY` input 1, `HRDATA` input 32, `HRESP` input 1: AHB-Lite responses.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA.
- IDLE:
  - `start`=1 with `len`≠0: latch pointers and count, clear `error` and `words_done`, go to RD_ADDR.
  - `start`=1 with `len`=0: clear `error`, pulse `done` next cycle, no bus traffic.
- RD_ADDR: HTRANS=NONSEQ, HADDR=src_ptr, HWRITE=0, HSIZE=3'b010. Hold until sampled HREADY=1, then go to RD_DATA.
- RD_DATA: HTRANS=IDLE. On HREADY=1:
  - HRESP=0: capture HRDATA into the data buffer, go to WR_ADDR.
  - HRESP=1: go to IDLE, set `error`, pulse `done`.
- WR_ADDR: HTRANS=NONSEQ, HADDR=dst_ptr, HWRITE=1, HSIZE=3'b010. On HREADY=1, go to WR_DATA.
- WR_DATA: HTRANS=IDLE, HWDATA=buffer, held stable across wait states. On HREADY=1:
  - HRESP=1: go to IDLE with `error` set and `done` pulsed.
  - Otherwise: increment `words_done`, add 4 to each pointer (modulo 2^32 wrap), decrement count. If count becomes 0, go to IDLE and pulse `done`; else go to RD_ADDR.
- An HRESP=1 seen with HREADY=0 (first error cycle) is tolerated; the outputs are already IDLE, so no cancellation is needed.
- HWDATA always drives the buffer register; it is don't-care outside WR_DATA but must not glitch within it.
- `busy`=1 in all states except IDLE.

## Timing
- All master outputs and status outputs are registered.
- Reset values (asynchronous): HTRANS=00, HADDR=0, HWRITE=0, HSIZE=010, HWDATA=0, `busy`=0, `done`=0, `error`=0, `words_done`=0, state=IDLE.
- Reset asserted mid-copy: HTRANS drops to IDLE immediately. No partial-word completion is reported.
- `start` sampled at edge k: HTRANS=NONSEQ and `busy`=1 from edge k+1.
- Zero wait states: 4 cycles per word. N words complete in 4N cycles from the first NONSEQ.
- `done`=1 and `busy`=0 in the cycle after the final write data phase completes.
- Each wait cycle (HREADY=0) stretches the current phase by exactly 1 cycle.
- `start` arriving in the same cycle as the `done` pulse is accepted, because state is already IDLE.

## Structure
- Shared package `ahb_pkg`:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
  - HSIZE_WORD, HBURST_SINGLE, HPROT default.
  - State enumeration for this block.
- Single module, no sub-module. Datapath (two pointers, counter, buffer) and FSM are small enough to live together.

## Test plan
- Zero-wait copy, src=0x0000_0100, dst=0x0000_0200, len=4, against the team's AHB-Lite memory model: memory words 0x80–0x83 equal 0x40–0x43; `done` 16 cycles after the first NONSEQ; `words_done`=4.
- Responder inserts 2 wait states on every data phase, len=1: copy completes in 8 cycles; HWDATA and HADDR remain stable through the waits.
- HRESP ERROR on the second read, len=3: `error`=1, `done` pulses once, `words_done`=1, no further NONSEQ issued.
- len=0 start: `done` pulses on the next cycle; HTRANS never leaves IDLE; `busy` stays 0.
- src=0xFFFF_FFFC, len=2: second read address is 0x0000_0000 (wrap).
- HRESETn asserted during WR_ADDR: HTRANS=00 and `busy`=0 immediately; a new `start` after reset performs a clean copy.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the copy-master state enumeration.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_DATA = 3'd4
    } copy_state_e;

endpackage

// File: rtl/ahb_copy_master.sv
// AHB-Lite word-copy initiator: non-pipelined single read then single write per word,
// stopping at the programmed length or on the first ERROR response.
module ahb_copy_master
    import ahb_pkg::*;
#(
    parameter int LENW = 16
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            start,
    input  logic [31:0]     src_addr,
    input  logic [31:0]     dst_addr,
    input  logic [LENW-1:0] len,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [LENW-1:0] words_done,
    output logic [31:0]     HADDR,
    output logic [1:0]      HTRANS,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [31:0]     HWDATA,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic            HMASTLOCK,
    input  logic            HREADY,
    input  logic [31:0]     HRDATA,
    input  logic            HRESP
);

    copy_state_e     state_q, state_d;
    logic [31:0]     src_ptr_q, src_ptr_d;
    logic [31:0]     dst_ptr_q, dst_ptr_d;
    logic [LENW-1:0] cnt_q, cnt_d;
    logic [31:0]     buf_q, buf_d;
    logic [31:0]     haddr_q, haddr_d;
    logic [1:0]      htrans_q, htrans_d;
    logic            hwrite_q, hwrite_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [LENW-1:0] words_done_q, words_done_d;

    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        error_d      = error_q;
        words_done_d = words_done_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (len != '0) begin
                        src_ptr_d    = {src_addr[31:2], 2'b00};
                        dst_ptr_d    = {dst_addr[31:2], 2'b00};
                        cnt_d        = len;
                        words_done_d = '0;
                        state_d      = ST_RD_ADDR;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (HREADY) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (HREADY) begin
                    if (HRESP) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        buf_d   = HRDATA;
                        state_d = ST_WR_ADDR;
                    end
                end
            end
            ST_WR_ADDR: begin
                if (HREADY) state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                if (HREADY) begin
                    if (HRESP) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        words_done_d = words_done_q + LENW'(1);
                        src_ptr_d    = src_ptr_q + 32'd4;
                        dst_ptr_d    = dst_ptr_q + 32'd4;
                        cnt_d        = cnt_q - LENW'(1);
                        if (cnt_q == LENW'(1)) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RD_ADDR;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus outputs are derived from the next state so they appear registered.
        // HADDR only moves on entry to an address phase, so it holds through data phases.
        haddr_d  = haddr_q;
        htrans_d = HTRANS_IDLE;
        if (state_d == ST_RD_ADDR) begin
            haddr_d  = src_ptr_d;
            htrans_d = HTRANS_NONSEQ;
        end else if (state_d == ST_WR_ADDR) begin
            haddr_d  = dst_ptr_d;
            htrans_d = HTRANS_NONSEQ;
        end
        hwrite_d = (state_d == ST_WR_ADDR) || (state_d == ST_WR_DATA);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            cnt_q        <= '0;
            buf_q        <= '0;
            haddr_q      <= '0;
            htrans_q     <= HTRANS_IDLE;
            hwrite_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            words_done_q <= '0;
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            haddr_q      <= haddr_d;
            htrans_q     <= htrans_d;
            hwrite_q     <= hwrite_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            words_done_q <= words_done_d;
        end
    end

    assign HADDR      = haddr_q;
    assign HTRANS     = htrans_q;
    assign HWRITE     = hwrite_q;
    assign HSIZE      = HSIZE_WORD;
    assign HWDATA     = buf_q;
    assign HBURST     = HBURST_SINGLE;
    assign HPROT      = HPROT_DEFAULT;
    assign HMASTLOCK  = 1'b0;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_ahb_copy_master.sv
// Directed bench for ahb_copy_master with a small AHB-Lite memory responder.
module tb_ahb_copy_master;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, error;
    logic [15:0] words_done;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    int n_tests = 0;
    int n_fail  = 0;

    ahb_copy_master #(.LENW(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .error(error), .words_done(words_done),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    // Memory responder: 256 words indexed by HADDR[9:2], configurable data-phase waits,
    // two-cycle ERROR on a selected read.
    logic [31:0] mem [256];
    logic        dp_valid, dp_write, dp_err;
    logic [31:0] dp_addr;
    int          wait_left;
    int          wait_cfg   = 0;
    int          err_rd_idx = -1;
    int          rd_total   = 0;
    int          ns_count   = 0;
    logic [31:0] rd_log [16];
    logic        next_err;

    assign HREADY   = !dp_valid || (wait_left == 0);
    assign HRESP    = dp_valid && dp_err;
    assign HRDATA   = (dp_valid && !dp_write) ? mem[dp_addr[9:2]] : 32'h0;
    assign next_err = !HWRITE && (rd_total == err_rd_idx);

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_err    <= 1'b0;
            dp_addr   <= '0;
            wait_left <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | i;
        end else if (HREADY) begin
            if (dp_valid && dp_write) mem[dp_addr[9:2]] <= HWDATA;
            if (HTRANS == 2'b10) begin
                dp_valid  <= 1'b1;
                dp_addr   <= HADDR;
                dp_write  <= HWRITE;
                dp_err    <= next_err;
                wait_left <= next_err ? 1 : wait_cfg;
                ns_count  <= ns_count + 1;
                if (!HWRITE) begin
                    rd_log[rd_total % 16] <= HADDR;
                    rd_total <= rd_total + 1;
                end
            end else begin
                dp_valid <= 1'b0;
            end
        end else begin
            wait_left <= wait_left - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one command and watches the bus; cycle 1 is the cycle after the start cycle.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            output int first_ns, output int done_cyc, output int pulses,
                            output int unstable, output int busy_seen);
        logic [31:0] p_addr, p_wdata;
        logic        p_ready, p_busy;
        first_ns = -1; done_cyc = -1; pulses = 0; unstable = 0; busy_seen = 0;
        @(negedge HCLK);
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        @(negedge HCLK);
        start = 1'b0;
        p_ready = 1'b1; p_busy = 1'b0; p_addr = '0; p_wdata = '0;
        for (int c = 1; c < 300; c++) begin
            if (busy) busy_seen = 1;
            if (HTRANS == 2'b10 && first_ns < 0) first_ns = c;
            if (done) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (p_busy && busy && !p_ready) begin
                if (HADDR !== p_addr) unstable++;
                if (HWRITE && HWDATA !== p_wdata) unstable++;
            end
            p_ready = HREADY; p_busy = busy; p_addr = HADDR; p_wdata = HWDATA;
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            @(negedge HCLK);
        end
    endtask

    int fns, dcyc, pls, unst, bsy, ns_base, rd_base;

    initial begin
        repeat (3) @(negedge HCLK);
        check("rst_htrans", {30'd0, HTRANS}, 32'h0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hsize", {29'd0, HSIZE}, 32'h2);
        check("rst_status", {28'd0, busy, done, error, HWRITE}, 32'h0);
        check("rst_words_done", {16'd0, words_done}, 32'h0);
        HRESETn = 1'b1;
        @(negedge HCLK);
        check("tied_sigs", {24'd0, HBURST, HPROT, HMASTLOCK}, {24'd0, 3'b000, 4'b0011, 1'b0});

        // Zero-wait copy of four words.
        run_copy(32'h0000_0100, 32'h0000_0200, 16'd4, fns, dcyc, pls, unst, bsy);
        check("t1_first_ns", fns, 32'd1);
        check("t1_done_latency", dcyc - fns, 32'd16);
        check("t1_done_pulses", pls, 32'd1);
        check("t1_words_done", {16'd0, words_done}, 32'd4);
        check("t1_error", {31'd0, error}, 32'd0);
        for (int i = 0; i < 4; i++)
            check("t1_mem", mem[8'h80 + i], 32'hC0DE_0040 + i);

        // Two wait states per data phase, one word, unaligned source forced to word.
        wait_cfg = 2;
        run_copy(32'h0000_0107, 32'h0000_0280, 16'd1, fns, dcyc, pls, unst, bsy);
        check("t2_done_latency", dcyc - fns, 32'd8);
        check("t2_stable", unst, 32'd0);
        check("t2_mem", mem[8'hA0], 32'hC0DE_0041);
        check("t2_words_done", {16'd0, words_done}, 32'd1);
        wait_cfg = 0;

        // ERROR on the second read of a three-word copy.
        ns_base = ns_count;
        err_rd_idx = rd_total + 1;
        run_copy(32'h0000_0110, 32'h0000_0290, 16'd3, fns, dcyc, pls, unst, bsy);
        repeat (4) @(negedge HCLK);
        err_rd_idx = -1;
        check("t3_error", {31'd0, error}, 32'd1);
        check("t3_done_pulses", pls, 32'd1);
        check("t3_words_done", {16'd0, words_done}, 32'd1);
        check("t3_nonseq_count", ns_count - ns_base, 32'd3);
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_mem_word0", mem[8'hA4], 32'hC0DE_0044);

        // Zero-length command: done next cycle, no traffic, error cleared.
        ns_base = ns_count;
        run_copy(32'h0000_0100, 32'h0000_0300, 16'd0, fns, dcyc, pls, unst, bsy);
        check("t4_done_cycle", dcyc, 32'd1);
        check("t4_no_nonseq", fns, 32'hFFFF_FFFF);
        check("t4_busy_seen", bsy, 32'd0);
        check("t4_error_cleared", {31'd0, error}, 32'd0);
        check("t4_nonseq_count", ns_count - ns_base, 32'd0);

        // Source pointer wraps past the top of the address space.
        rd_base = rd_total;
        run_copy(32'hFFFF_FFFC, 32'h0000_0300, 16'd2, fns, dcyc, pls, unst, bsy);
        check("t5_rd_addr0", rd_log[rd_base % 16], 32'hFFFF_FFFC);
        check("t5_rd_addr1", rd_log[(rd_base + 1) % 16], 32'h0000_0000);
        check("t5_mem0", mem[8'hC0], 32'hC0DE_00FF);
        check("t5_mem1", mem[8'hC1], 32'hC0DE_0000);
        check("t5_words_done", {16'd0, words_done}, 32'd2);

        // Reset during the write address phase, then a clean copy.
        @(negedge HCLK);
        start = 1'b1; src_addr = 32'h0000_0100; dst_addr = 32'h0000_0380; len = 16'd2;
        @(negedge HCLK);
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (HTRANS == 2'b10 && HWRITE) break;
            @(negedge HCLK);
        end
        check("t6_in_wr_addr", {30'd0, HTRANS, HWRITE}, {29'd0, 2'b10, 1'b1});
        HRESETn = 1'b0;
        #1;
        check("t6_rst_htrans", {30'd0, HTRANS}, 32'h0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_words_done", {16'd0, words_done}, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        run_copy(32'h0000_0100, 32'h0000_0380, 16'd1, fns, dcyc, pls, unst, bsy);
        check("t6_done_latency", dcyc - fns, 32'd4);
        check("t6_mem", mem[8'hE0], 32'hC0DE_0040);
        check("t6_words_done", {16'd0, words_done}, 32'd1);
        check("t6_error", {31'd0, error}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
